// File: rtl/line_shift_ctrl_if.sv
// Port bundle between the line-shift controller and its single-clock line FIFO.
// The controller owns the write/read/reset side; the FIFO returns data and flags.
interface line_shift_ctrl_if #(
    parameter int DW = 8
);
    logic [DW-1:0] fifo_di;
    logic          fifo_we;
    logic          fifo_re;
    logic          fifo_rst;
    logic [DW-1:0] fifo_do;
    logic          fifo_empty;
    logic          fifo_full;

    modport master (
        output fifo_di, fifo_we, fifo_re, fifo_rst,
        input  fifo_do, fifo_empty, fifo_full
    );

    modport slave (
        input  fifo_di, fifo_we, fifo_re, fifo_rst,
        output fifo_do, fifo_empty, fifo_full
    );
endinterface

// File: rtl/line_shift_ctrl.sv
// Pairs each incoming pixel with the pixel one line above it, using an external
// line FIFO as a one-line delay; reports FIFO underflow/overflow as sticky errors.
module line_shift_ctrl #(
    parameter int IMG_WIDTH = 640,
    parameter int DW        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   pix_vld,
    input  logic [DW-1:0]          pix_data,
    line_shift_ctrl_if.master      fifo,
    output logic                   out_vld,
    output logic [DW-1:0]          out_cur,
    output logic [DW-1:0]          out_prev,
    output logic [11:0]            out_col,
    output logic [1:0]             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        FILL  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    localparam logic [11:0] LAST_COL = 12'(IMG_WIDTH - 1);

    state_t      state;
    state_t      state_nxt;
    logic [11:0] col;
    logic        accept;
    logic        last_col;
    logic        prev_sel;

    assign last_col = (col == LAST_COL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // frame_start wins over everything, and a pixel arriving with it is dropped.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        fifo.fifo_we  = 1'b0;
        fifo.fifo_re  = 1'b0;
        fifo.fifo_di  = pix_data;
        fifo.fifo_rst = rst || (state == FLUSH);
        if (frame_start) begin
            state_nxt = FLUSH;
        end else begin
            case (state)
                IDLE:  state_nxt = IDLE;
                FLUSH: state_nxt = FILL;
                FILL: begin
                    accept       = pix_vld;
                    fifo.fifo_we = pix_vld && !fifo.fifo_full;
                    if (pix_vld && last_col) begin
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    accept       = pix_vld;
                    fifo.fifo_we = pix_vld && !fifo.fifo_full;
                    fifo.fifo_re = pix_vld && !fifo.fifo_empty;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs register one cycle after acceptance so they line up with fifo_do.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col      <= '0;
            err      <= '0;
            out_vld  <= 1'b0;
            out_cur  <= '0;
            out_col  <= '0;
            prev_sel <= 1'b0;
        end else begin
            out_vld  <= accept;
            prev_sel <= fifo.fifo_re;
            if (frame_start || state == FLUSH) begin
                col <= '0;
                err <= '0;
            end else if (accept) begin
                col     <= last_col ? 12'd0 : col + 12'd1;
                out_cur <= pix_data;
                out_col <= col;
                if (fifo.fifo_full) begin
                    err[1] <= 1'b1;
                end
                if (state == SHIFT && fifo.fifo_empty) begin
                    err[0] <= 1'b1;
                end
            end
        end
    end

    assign out_prev = prev_sel ? fifo.fifo_do : '0;

endmodule

// File: tb/tb_line_shift_ctrl.sv
// Directed bench for line_shift_ctrl with IMG_WIDTH=4 and a behavioural line FIFO
// whose empty/full flags can be forced to provoke the error paths.
module tb_line_shift_ctrl;

    localparam int W  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          pix_vld = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          out_vld;
    logic [DW-1:0] out_cur;
    logic [DW-1:0] out_prev;
    logic [11:0]   out_col;
    logic [1:0]    err;

    logic          force_empty = 1'b0;
    logic          force_full  = 1'b0;

    int checks = 0;
    int errors = 0;

    line_shift_ctrl_if #(.DW(DW)) fif ();

    line_shift_ctrl #(.IMG_WIDTH(W), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_vld     (pix_vld),
        .pix_data    (pix_data),
        .fifo        (fif.master),
        .out_vld     (out_vld),
        .out_cur     (out_cur),
        .out_prev    (out_prev),
        .out_col     (out_col),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: read data appears on the edge after fifo_re.
    logic [DW-1:0] mem [16];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            count  = 0;
    logic [DW-1:0] do_q   = '0;

    assign fif.fifo_do    = do_q;
    assign fif.fifo_empty = (count == 0) || force_empty;
    assign fif.fifo_full  = (count >= 16) || force_full;

    always @(posedge clk) begin
        if (fif.fifo_rst) begin
            wr_ptr <= 0;
            rd_ptr <= 0;
            count  <= 0;
            do_q   <= '0;
        end else begin
            if (fif.fifo_re) begin
                do_q   <= mem[rd_ptr];
                rd_ptr <= (rd_ptr + 1) % 16;
            end
            if (fif.fifo_we) begin
                mem[wr_ptr] <= fif.fifo_di;
                wr_ptr      <= (wr_ptr + 1) % 16;
            end
            count <= count + int'(fif.fifo_we) - int'(fif.fifo_re);
        end
    end

    task automatic drive(input logic fs, input logic vld, input logic [DW-1:0] d);
        @(negedge clk);
        frame_start = fs;
        pix_vld     = vld;
        pix_data    = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        drive(1'b1, 1'b0, '0);
        tick();
        drive(1'b0, 1'b0, '0);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (fif.fifo_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_fifo_rst got %b exp 1", fif.fifo_rst); end
        checks++; if (fif.fifo_we !== 1'b0 || fif.fifo_re !== 1'b0) begin errors++; $display("[TB] FAIL reset_we_re got %b%b exp 00", fif.fifo_we, fif.fifo_re); end
        checks++; if ({out_vld, out_cur, out_prev, out_col, err} !== '0) begin errors++; $display("[TB] FAIL reset_outputs got %b/%0h/%0h/%0d/%b exp all 0", out_vld, out_cur, out_prev, out_col, err); end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 8'h55);
        #1;
        checks++; if (fif.fifo_we !== 1'b0) begin errors++; $display("[TB] FAIL idle_ignore_we got %b exp 0", fif.fifo_we); end
        tick();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL idle_ignore_vld got %b exp 0", out_vld); end
    endtask

    task automatic test_stream();
        drive(1'b1, 1'b0, '0);
        tick();
        drive(1'b0, 1'b0, '0);
        #1;
        checks++; if (fif.fifo_rst !== 1'b1) begin errors++; $display("[TB] FAIL flush_pulse got %b exp 1", fif.fifo_rst); end
        tick();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, DW'(i));
            #1;
            checks++; if (fif.fifo_rst !== 1'b0) begin errors++; $display("[TB] FAIL stream_rst_low px%0d got %b exp 0", i, fif.fifo_rst); end
            checks++; if (fif.fifo_we !== 1'b1 || fif.fifo_re !== (i > W)) begin errors++; $display("[TB] FAIL stream_we_re px%0d got %b%b exp 1%b", i, fif.fifo_we, fif.fifo_re, (i > W)); end
            tick();
            checks++; if (out_vld !== 1'b1 || out_cur !== DW'(i)) begin errors++; $display("[TB] FAIL stream_cur px%0d got %b/%0d exp 1/%0d", i, out_vld, out_cur, i); end
            checks++; if (out_col !== 12'((i - 1) % W)) begin errors++; $display("[TB] FAIL stream_col px%0d got %0d exp %0d", i, out_col, (i - 1) % W); end
            checks++; if (out_prev !== ((i > W) ? DW'(i - W) : DW'(0))) begin errors++; $display("[TB] FAIL stream_prev px%0d got %0d exp %0d", i, out_prev, (i > W) ? i - W : 0); end
        end
        drive(1'b0, 1'b0, '0);
        tick();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL stream_idle_vld got %b exp 0", out_vld); end
        checks++; if (err !== 2'b00) begin errors++; $display("[TB] FAIL stream_err got %b exp 00", err); end
    endtask

    task automatic test_gaps();
        start_frame();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, DW'(i));
            tick();
            checks++; if (out_vld !== 1'b1 || out_cur !== DW'(i) || out_col !== 12'((i - 1) % W)) begin errors++; $display("[TB] FAIL gaps_cur px%0d got %b/%0d/%0d exp 1/%0d/%0d", i, out_vld, out_cur, out_col, i, (i - 1) % W); end
            checks++; if (out_prev !== ((i > W) ? DW'(i - W) : DW'(0))) begin errors++; $display("[TB] FAIL gaps_prev px%0d got %0d exp %0d", i, out_prev, (i > W) ? i - W : 0); end
            drive(1'b0, 1'b0, 8'hEE);
            #1;
            checks++; if (fif.fifo_we !== 1'b0 || fif.fifo_re !== 1'b0) begin errors++; $display("[TB] FAIL gaps_stall px%0d got %b%b exp 00", i, fif.fifo_we, fif.fifo_re); end
            tick();
            checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL gaps_vld px%0d got %b exp 0", i, out_vld); end
        end
        checks++; if (err !== 2'b00) begin errors++; $display("[TB] FAIL gaps_err got %b exp 00", err); end
    endtask

    task automatic test_frame_restart();
        start_frame();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, DW'(i));
            tick();
        end
        drive(1'b1, 1'b1, 8'd6);
        #1;
        checks++; if (fif.fifo_we !== 1'b0 || fif.fifo_re !== 1'b0) begin errors++; $display("[TB] FAIL restart_drop_we_re got %b%b exp 00", fif.fifo_we, fif.fifo_re); end
        tick();
        checks++; if (out_vld !== 1'b0 || err !== 2'b00) begin errors++; $display("[TB] FAIL restart_drop_out got %b/%b exp 0/00", out_vld, err); end
        drive(1'b0, 1'b1, 8'd99);
        #1;
        checks++; if (fif.fifo_rst !== 1'b1 || fif.fifo_we !== 1'b0) begin errors++; $display("[TB] FAIL restart_flush got rst %b we %b exp 1 0", fif.fifo_rst, fif.fifo_we); end
        tick();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL restart_flush_vld got %b exp 0", out_vld); end
        drive(1'b0, 1'b1, 8'd7);
        tick();
        checks++; if (out_vld !== 1'b1 || out_cur !== 8'd7 || out_col !== 12'd0 || out_prev !== 8'd0) begin errors++; $display("[TB] FAIL restart_first got %b/%0d/%0d/%0d exp 1/7/0/0", out_vld, out_cur, out_col, out_prev); end
    endtask

    task automatic test_underflow();
        start_frame();
        for (int i = 1; i <= W; i++) begin
            drive(1'b0, 1'b1, DW'(i));
            tick();
        end
        drive(1'b0, 1'b1, 8'd5);
        force_empty = 1'b1;
        #1;
        checks++; if (fif.fifo_re !== 1'b0 || fif.fifo_we !== 1'b1) begin errors++; $display("[TB] FAIL under_re got re %b we %b exp 0 1", fif.fifo_re, fif.fifo_we); end
        tick();
        checks++; if (out_vld !== 1'b1 || out_cur !== 8'd5 || out_prev !== 8'd0) begin errors++; $display("[TB] FAIL under_out got %b/%0d/%0d exp 1/5/0", out_vld, out_cur, out_prev); end
        checks++; if (err !== 2'b01) begin errors++; $display("[TB] FAIL under_err got %b exp 01", err); end
        drive(1'b0, 1'b1, 8'd6);
        force_empty = 1'b0;
        tick();
        checks++; if (err !== 2'b01) begin errors++; $display("[TB] FAIL under_sticky got %b exp 01", err); end
        drive(1'b1, 1'b0, '0);
        tick();
        checks++; if (err !== 2'b00) begin errors++; $display("[TB] FAIL under_clear got %b exp 00", err); end
        drive(1'b0, 1'b0, '0);
        tick();
    endtask

    task automatic test_overflow();
        start_frame();
        drive(1'b0, 1'b1, 8'd1);
        force_full = 1'b1;
        #1;
        checks++; if (fif.fifo_we !== 1'b0) begin errors++; $display("[TB] FAIL over_we got %b exp 0", fif.fifo_we); end
        tick();
        force_full = 1'b0;
        checks++; if (out_vld !== 1'b1 || out_cur !== 8'd1 || out_col !== 12'd0) begin errors++; $display("[TB] FAIL over_out got %b/%0d/%0d exp 1/1/0", out_vld, out_cur, out_col); end
        checks++; if (err !== 2'b10) begin errors++; $display("[TB] FAIL over_err got %b exp 10", err); end
        drive(1'b0, 1'b1, 8'd2);
        #1;
        checks++; if (fif.fifo_we !== 1'b1) begin errors++; $display("[TB] FAIL over_resume_we got %b exp 1", fif.fifo_we); end
        tick();
    endtask

    task automatic test_reset_mid();
        start_frame();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b0, 1'b1, DW'(i + 16));
            tick();
        end
        @(negedge clk);
        rst      = 1'b1;
        pix_vld  = 1'b1;
        pix_data = 8'd40;
        #1;
        checks++; if (fif.fifo_we !== 1'b0 || fif.fifo_re !== 1'b0 || fif.fifo_rst !== 1'b1) begin errors++; $display("[TB] FAIL midrst_fifo got we %b re %b rst %b exp 0 0 1", fif.fifo_we, fif.fifo_re, fif.fifo_rst); end
        tick();
        checks++; if ({out_vld, out_cur, out_prev, out_col, err} !== '0) begin errors++; $display("[TB] FAIL midrst_outputs got %b/%0h/%0h/%0d/%b exp all 0", out_vld, out_cur, out_prev, out_col, err); end
        @(negedge clk);
        rst      = 1'b0;
        pix_data = 8'd41;
        #1;
        checks++; if (fif.fifo_we !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ignore_we got %b exp 0", fif.fifo_we); end
        tick();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ignore_vld got %b exp 0", out_vld); end
        start_frame();
        drive(1'b0, 1'b1, 8'd42);
        tick();
        checks++; if (out_vld !== 1'b1 || out_cur !== 8'd42 || out_col !== 12'd0 || out_prev !== 8'd0) begin errors++; $display("[TB] FAIL midrst_restart got %b/%0d/%0d/%0d exp 1/42/0/0", out_vld, out_cur, out_col, out_prev); end
        drive(1'b0, 1'b0, '0);
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_frame_restart();
        test_underflow();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_shift_ctrl.md
LINE_SHIFT_CTRL -- requirements
Module: line_shift_ctrl

Interface
REQ-001 Parameter IMG_WIDTH, default 640, SHALL set pixels per line (range 2..4095).
REQ-002 Parameter DW, default 8, SHALL set pixel width (FIFO data width).
REQ-003 clk  input  1  sole clock; FIFO clkr/clkw share it.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle pulse before the first pixel of a frame.
REQ-006 pix_vld  input  1  pix_data valid this cycle.
REQ-007 pix_data  input  DW  incoming pixel.
REQ-008 fifo_di  output  DW  write data to line FIFO.
REQ-009 fifo_we  output  1  FIFO write enable.
REQ-010 fifo_re  output  1  FIFO read enable.
REQ-011 fifo_rst  output  1  FIFO reset (drives both rst and rprst).
REQ-012 fifo_do  input  DW  FIFO read data, valid one cycle after fifo_re (unregistered output).
REQ-013 fifo_empty  input  1  FIFO empty flag.
REQ-014 fifo_full  input  1  FIFO full flag.
REQ-015 out_vld  output  1  aligned pixel pair valid.
REQ-016 out_cur  output  DW  current-line pixel.
REQ-017 out_prev  output  DW  same column, previous line.
REQ-018 out_col  output  12  column index of out_cur.
REQ-019 err  output  2  sticky: [0] underflow, [1] overflow.

Function
REQ-020 The block SHALL implement states IDLE, FLUSH, FILL, SHIFT.
REQ-021 IDLE: pix_vld ignored; frame_start -> FLUSH.
REQ-022 FLUSH: fifo_rst=1 for exactly one cycle, col counter cleared, err cleared, then -> FILL.
REQ-023 FILL: each pix_vld SHALL assert fifo_we with fifo_di=pix_data combinationally, fifo_re=0.
REQ-024 SHIFT: each pix_vld SHALL assert fifo_we and fifo_re in the same cycle.
REQ-025 Column counter SHALL increment per accepted pixel, wrap IMG_WIDTH-1 -> 0.
REQ-026 FILL -> SHIFT on the accepted pixel at column IMG_WIDTH-1.
REQ-027 Latency: out_vld, out_cur, out_col SHALL be registered one cycle after the accepting pix_vld, aligning out_cur with fifo_do.
REQ-028 out_prev SHALL equal fifo_do for pixels accepted in SHIFT; 0 for pixels accepted in FILL.
REQ-029 fifo_we SHALL be suppressed when fifo_full=1; err[1] set; pixel still output.
REQ-030 In SHIFT, pix_vld with fifo_empty=1 SHALL suppress fifo_re, set err[0], force out_prev=0 for that pixel.
REQ-031 frame_start in any state SHALL enter FLUSH; a pix_vld in the same cycle SHALL be discarded without error and no out_vld.
REQ-032 pix_vld in FLUSH SHALL be discarded (fifo_we=0, out_vld=0).
REQ-033 Gaps in pix_vld SHALL stall counters and state; FIFO occupancy in SHIFT SHALL stay IMG_WIDTH.
REQ-034 fifo_we, fifo_re SHALL never assert while fifo_rst=1.

Reset
REQ-035 rst SHALL force: state IDLE, col=0, out_vld=0, out_cur=0, out_prev=0, out_col=0, err=0, fifo_rst=1 while rst high.
REQ-036 fifo_we, fifo_re SHALL be 0 during rst.
REQ-037 rst mid-line SHALL abandon the frame; restart requires frame_start.

Verification
REQ-038 IMG_WIDTH=4, frame_start then 8 pixels 1..8 -> out_prev 0,0,0,0,1,2,3,4; out_cur 1..8; out_col 0..3,0..3; one cycle late.
REQ-039 Same stream with pix_vld toggling every other cycle -> identical output sequence, err=0.
REQ-040 frame_start coincident with pixel 6 -> fifo_rst pulse, pixel 6 dropped, next pixel out_col=0, out_prev=0.
REQ-041 Force fifo_empty=1 in SHIFT at one pixel -> fifo_re=0, out_prev=0, err=2'b01 held until next frame_start.
REQ-042 Force fifo_full=1 during FILL -> fifo_we=0 that cycle, err=2'b10.
REQ-043 Assert rst during SHIFT -> all outputs 0 next edge, pixels ignored until frame_start.
